// File: rtl/multicycle_sequencer_if.sv
// Control bundle between the multicycle sequencer and its memory/datapath.
// The master side (sequencer) drives the control strobes and status; the
// slave side (memory + datapath) returns read data, ready and branch outcome.
interface multicycle_sequencer_if;
  // Memory / datapath to sequencer
  logic [31:0] MemRData;
  logic        MemReady;
  logic        BranchTaken;

  // Sequencer to memory / datapath
  logic [31:0] Instr;
  logic        MemReq;
  logic        MemAddrSel;
  logic [1:0]  MemWrite;
  logic        IRWrite;
  logic        PCWrite;
  logic [1:0]  PCSrc;
  logic        RegWrite;
  logic [2:0]  State;
  logic        Illegal;
  logic [31:0] Retired;

  modport master (
    input  MemRData, MemReady, BranchTaken,
    output Instr, MemReq, MemAddrSel, MemWrite, IRWrite, PCWrite,
           PCSrc, RegWrite, State, Illegal, Retired
  );

  modport slave (
    output MemRData, MemReady, BranchTaken,
    input  Instr, MemReq, MemAddrSel, MemWrite, IRWrite, PCWrite,
           PCSrc, RegWrite, State, Illegal, Retired
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multicycle RISC-V style control sequencer.
// Walks FETCH -> DECODE -> EXECUTE -> (MEMACC) -> (WRITEBACK) per instruction,
// holds the instruction register and counts retired instructions. Control
// strobes are decoded combinationally from the current state, the held
// instruction and the live MemReady/BranchTaken inputs; they are forced low
// while reset is high so nothing fires during a reset cycle.
module multicycle_sequencer #(
  parameter logic [31:0] RESET_IR = 32'h00000013
) (
  input  logic                         clk,
  input  logic                         reset,
  multicycle_sequencer_if.master       bus
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMACC    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_ILLEGAL   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Every opcode the sequencer knows how to run; anything else traps.
  localparam int NUM_OPS = 10;
  localparam logic [6:0] LEGAL_OPS [NUM_OPS] = '{
    7'b0110011, 7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011,
    7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0001011
  };

  state_t      state_reg;
  logic [31:0] instr_reg;
  logic [31:0] retired_reg;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [NUM_OPS-1:0] op_hit;
  logic        op_legal;
  logic        is_load;
  logic        is_store;
  logic        is_branch;
  logic [1:0]  store_size;

  logic        mem_req;
  logic        mem_addr_sel;
  logic [1:0]  mem_write;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        reg_write;

  assign opcode    = instr_reg[6:0];
  assign funct3    = instr_reg[14:12];
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);

  // One comparator per legal opcode, OR-reduced into the legality flag.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPS; gi++) begin : g_legal
      assign op_hit[gi] = (opcode == LEGAL_OPS[gi]);
    end
  endgenerate
  assign op_legal = |op_hit;

  // Store width from funct3: SB=11, SH=10, SW and anything unexpected=01.
  always_comb begin
    case (funct3)
      3'b000:  store_size = 2'b11;
      3'b001:  store_size = 2'b10;
      default: store_size = 2'b01;
    endcase
  end

  // Control strobe decode; everything defaults low and stays low in reset.
  always_comb begin
    mem_req      = 1'b0;
    mem_addr_sel = 1'b0;
    mem_write    = 2'b00;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    reg_write    = 1'b0;
    if (!reset) begin
      case (state_reg)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = bus.MemReady;
        end
        S_EXECUTE: begin
          if (is_branch) begin
            pc_write = 1'b1;
            pc_src   = bus.BranchTaken ? 2'b01 : 2'b00;
          end
        end
        S_MEMACC: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          if (is_store) begin
            mem_write = store_size;
            pc_write  = bus.MemReady;
          end
        end
        S_WRITEBACK: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          if (opcode == OP_JAL)
            pc_src = 2'b01;
          else if (opcode == OP_JALR)
            pc_src = 2'b10;
        end
        default: ;
      endcase
    end
  end

  // State machine, instruction register and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      instr_reg   <= RESET_IR;
      retired_reg <= 32'd0;
    end else begin
      if (pc_write)
        retired_reg <= retired_reg + 32'd1;
      case (state_reg)
        S_FETCH: begin
          if (bus.MemReady) begin
            instr_reg <= bus.MemRData;
            state_reg <= S_DECODE;
          end
        end
        S_DECODE: begin
          state_reg <= op_legal ? S_EXECUTE : S_ILLEGAL;
        end
        S_EXECUTE: begin
          if (is_load || is_store)
            state_reg <= S_MEMACC;
          else if (is_branch)
            state_reg <= S_FETCH;
          else
            state_reg <= S_WRITEBACK;
        end
        S_MEMACC: begin
          if (bus.MemReady)
            state_reg <= is_load ? S_WRITEBACK : S_FETCH;
        end
        S_WRITEBACK: begin
          state_reg <= S_FETCH;
        end
        S_ILLEGAL: begin
          state_reg <= S_ILLEGAL;
        end
        default: begin
          state_reg <= S_FETCH;
        end
      endcase
    end
  end

  assign bus.Instr      = instr_reg;
  assign bus.MemReq     = mem_req;
  assign bus.MemAddrSel = mem_addr_sel;
  assign bus.MemWrite   = mem_write;
  assign bus.IRWrite    = ir_write;
  assign bus.PCWrite    = pc_write;
  assign bus.PCSrc      = pc_src;
  assign bus.RegWrite   = reg_write;
  assign bus.State      = state_reg;
  assign bus.Illegal    = (state_reg == S_ILLEGAL);
  assign bus.Retired    = retired_reg;

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 SHALL provide parameter RESET_IR, default 32'h00000013, the value loaded into Instr on reset (a NOP).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port MemRData, input, 32 bits: memory read data, captured as the instruction in FETCH.
REQ-005 SHALL have port MemReady, input, 1 bit: memory completes the current MemReq access this cycle.
REQ-006 SHALL have port BranchTaken, input, 1 bit: branch condition from the datapath, sampled in EXECUTE.
REQ-007 SHALL have port Instr, output, 32 bits: the registered instruction (IR).
REQ-008 SHALL have port MemReq, output, 1 bit: memory access request.
REQ-009 SHALL have port MemAddrSel, output, 1 bit: address source, 0 = PC, 1 = ALU result.
REQ-010 SHALL have port MemWrite, output, 2 bits: store size, 00 none, 01 SW, 10 SH, 11 SB.
REQ-011 SHALL have port IRWrite, output, 1 bit: IR load strobe.
REQ-012 SHALL have port PCWrite, output, 1 bit: PC update strobe.
REQ-013 SHALL have port PCSrc, output, 2 bits: next-PC select, 00 PC+4, 01 PC+imm, 10 ALU (JALR).
REQ-014 SHALL have port RegWrite, output, 1 bit: register-file write strobe.
REQ-015 SHALL have port State, output, 3 bits: current state.
REQ-016 SHALL have port Illegal, output, 1 bit: asserted while in the ILLEGAL state.
REQ-017 SHALL have port Retired, output, 32 bits: count of retired instructions.

Function
REQ-018 SHALL implement states FETCH=0, DECODE=1, EXECUTE=2, MEMACC=3, WRITEBACK=4, ILLEGAL=5; encodings 6 and 7 SHALL go to FETCH on the next cycle.
REQ-019 FETCH SHALL drive MemReq=1 and MemAddrSel=0 and wait until MemReady.
- When MemReady=1, IRWrite SHALL be 1 and Instr<=MemRData at that edge.
- The state SHALL then go to DECODE.
REQ-020 DECODE SHALL last 1 cycle.
- Instr[6:0] in {0110011, 0000011, 0010011, 1100111, 0100011, 1100011, 0110111, 0010111, 1101111, 0001011} SHALL go to EXECUTE.
- Any other opcode SHALL go to ILLEGAL.
REQ-021 EXECUTE SHALL last 1 cycle.
- LOAD (0000011) and STORE (0100011) SHALL go to MEMACC.
- BRANCH (1100011) SHALL assert PCWrite=1 with PCSrc=01 if BranchTaken, else 00, and go to FETCH.
- All other opcodes SHALL go to WRITEBACK.
REQ-022 MEMACC SHALL drive MemReq=1 and MemAddrSel=1; for STORE it SHALL drive MemWrite from funct3: 000->11, 001->10, 010->01, others->01.
- MemWrite SHALL be held for every cycle until MemReady.
- On MemReady, LOAD SHALL go to WRITEBACK.
- On MemReady, STORE SHALL assert PCWrite=1, PCSrc=00, and go to FETCH.
REQ-023 WRITEBACK SHALL last 1 cycle with RegWrite=1 and PCWrite=1, then go to FETCH.
- PCSrc SHALL be 01 for JAL, 10 for JALR, 00 otherwise.
REQ-024 ILLEGAL SHALL be absorbing until reset: Illegal=1 and all strobes 0 (MemReq, IRWrite, PCWrite, RegWrite, MemWrite).
REQ-025 Strobes SHALL be combinational from State, Instr, MemReady and BranchTaken; any strobe not named for a state SHALL be 0.
REQ-026 Retired SHALL increment by 1 on every cycle with PCWrite=1, wrapping 32'hFFFFFFFF->0.
REQ-027 Instruction latency with zero memory wait SHALL be:
- BRANCH: 3 cycles.
- ALU, LUI, AUIPC, XORID, JAL, JALR: 4 cycles.
- STORE: 4 cycles.
- LOAD: 5 cycles.
- Each MemReady wait cycle SHALL add 1 cycle.
REQ-028 MemReady outside FETCH and MemACC SHALL be ignored; BranchTaken outside EXECUTE of a BRANCH SHALL be ignored.

Reset
REQ-029 While reset=1, all strobes and MemReq SHALL be 0 in that same cycle, regardless of state.
REQ-030 At the reset edge: State<=FETCH, Instr<=RESET_IR, Retired<=0; reset SHALL take priority over any in-progress transition, including mid-MEMACC and ILLEGAL.

Verification
REQ-031 Reset, then ADD 32'h002081B3 with MemReady=1 -> states 0,1,2,4; cycle 4 has RegWrite=1, PCWrite=1, PCSrc=00; Retired=1.
REQ-032 SW 32'h0020A223 with MemReady low for 3 MEMACC cycles -> MemReq=1 and MemWrite=01 for 4 cycles, one PCWrite, RegWrite never 1.
REQ-033 BEQ 32'h00208463 with BranchTaken=1 -> EXECUTE PCWrite=1, PCSrc=01, back in FETCH after 3 cycles; with BranchTaken=0 -> PCSrc=00.
REQ-034 JALR 32'h000080E7 -> WRITEBACK RegWrite=1, PCSrc=10; JAL 32'h008000EF -> PCSrc=01.
REQ-035 Fetch 32'h0000007F -> State=5, Illegal=1, all strobes 0 for 10+ cycles; reset -> State=0, Instr=32'h00000013.
REQ-036 LW 32'h0000A103 with reset asserted during MEMACC -> strobes 0 in the reset cycle, next State=0, Retired=0; Retired preload 32'hFFFFFFFF plus one retire -> 0.
